// File: rtl/display_list_sequencer_if.sv
// display_list_sequencer_if: display-list RAM port and line-drawer handshake bundle
interface display_list_sequencer_if #(
  parameter int ADDR_W  = 10,
  parameter int COORD_W = 12
);
  logic [ADDR_W-1:0]      mem_addr;
  logic                   mem_rd;
  logic [2+2*COORD_W-1:0] mem_data;
  logic [COORD_W-1:0]     x;
  logic [COORD_W-1:0]     y;
  logic                   draw;
  logic                   jump;
  logic                   ready;
  modport master (output mem_addr, mem_rd, x, y, draw, jump, input mem_data, ready);
  modport slave  (input mem_addr, mem_rd, x, y, draw, jump, output mem_data, ready);
endinterface

// File: rtl/display_list_sequencer.sv
// display_list_sequencer: walks a vector display list and feeds the line drawer one command at a time
module display_list_sequencer #(
  parameter int ADDR_W  = 10,
  parameter int COORD_W = 12,
  parameter int HOLDOFF = 2,
  parameter int PARK_X  = 0,
  parameter int PARK_Y  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic              i_loop_en,
  input  logic [ADDR_W-1:0] i_base_addr,
  output logic              o_busy,
  output logic              o_frame_done,
  display_list_sequencer_if.master bus
);
  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_ISSUE, S_HOLD, S_PARK, S_HOLD2, S_DONE
  } state_t;
  localparam logic [1:0] OP_DRAW = 2'b00;
  localparam logic [1:0] OP_JUMP = 2'b01;
  localparam logic [1:0] OP_HALT = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;
  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_op;
  logic [ADDR_W-1:0]   r_ptr;
  logic [COORD_W-1:0]  r_x;
  logic [COORD_W-1:0]  r_y;
  logic [3:0]          r_cnt;
  logic                r_stop;
  logic                w_stop;
  logic [1:0]          w_op;
  assign w_op         = bus.mem_data[2*COORD_W +: 2];
  assign w_stop       = r_stop | i_stop;
  assign bus.mem_addr = r_ptr;
  assign bus.mem_rd   = r_state == S_FETCH;
  assign bus.x        = r_x;
  assign bus.y        = r_y;
  assign bus.draw     = bus.ready && r_state == S_ISSUE && r_op == OP_DRAW;
  assign bus.jump     = bus.ready && (r_state == S_PARK || (r_state == S_ISSUE && r_op == OP_JUMP));
  assign o_busy       = r_state != S_IDLE;
  assign o_frame_done = bus.ready && r_state == S_DONE;
  // next-state: pulses are only ever produced in ISSUE/PARK with ready high, holdoff states ignore ready
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = i_start ? S_FETCH : S_IDLE;
      S_FETCH:  w_next = S_WAIT;
      S_WAIT:   w_next = S_DECODE;
      S_DECODE: w_next = (w_stop || w_op == OP_HALT) ? S_PARK : w_op == OP_NOP ? S_FETCH : S_ISSUE;
      S_ISSUE:  w_next = bus.ready ? S_HOLD : S_ISSUE;
      S_HOLD:   w_next = r_cnt != 4'd0 ? S_HOLD : w_stop ? S_PARK : S_FETCH;
      S_PARK:   w_next = bus.ready ? S_HOLD2 : S_PARK;
      S_HOLD2:  w_next = r_cnt != 4'd0 ? S_HOLD2 : S_DONE;
      S_DONE:   w_next = !bus.ready ? S_DONE : (i_loop_en && !w_stop) ? S_FETCH : S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end
  // state, list pointer, command word, target coordinates, holdoff counter and stop latch
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_op    <= OP_DRAW;
      r_ptr   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_cnt   <= '0;
      r_stop  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_stop  <= w_next == S_IDLE ? 1'b0 : (r_stop | i_stop);
      r_cnt   <= (bus.draw || bus.jump) ? 4'(HOLDOFF - 1) : r_cnt == 4'd0 ? 4'd0 : r_cnt - 4'd1;
      if ((r_state == S_IDLE && i_start) || (r_state == S_DONE && w_next == S_FETCH))
        r_ptr <= i_base_addr;
      else if ((r_state == S_DECODE && w_next == S_FETCH) || (r_state == S_ISSUE && bus.ready))
        r_ptr <= r_ptr + ADDR_W'(1);
      if (r_state == S_DECODE)
        r_op <= w_op;
      if (r_state == S_DECODE && w_next == S_ISSUE)
        {r_x, r_y} <= bus.mem_data[2*COORD_W-1:0];
      else if (w_next == S_PARK && r_state != S_PARK)
        {r_x, r_y} <= {COORD_W'(PARK_X), COORD_W'(PARK_Y)};
    end
  end
endmodule

// File: tb/tb_display_list_sequencer.sv
// tb_display_list_sequencer: random and directed frames checked against a list-walking reference model
module tb_display_list_sequencer;
  localparam int AW = 10;
  localparam int CW = 12;
  localparam int HO = 2;
  logic          clk = 1'b0;
  logic          reset;
  logic          i_start;
  logic          i_stop;
  logic          i_loop_en;
  logic [AW-1:0] i_base_addr;
  logic          o_busy;
  logic          o_frame_done;
  display_list_sequencer_if #(.ADDR_W(AW), .COORD_W(CW)) bus();
  display_list_sequencer #(.ADDR_W(AW), .COORD_W(CW), .HOLDOFF(HO), .PARK_X(0), .PARK_Y(0)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_stop(i_stop), .i_loop_en(i_loop_en),
    .i_base_addr(i_base_addr), .o_busy(o_busy), .o_frame_done(o_frame_done), .bus(bus)
  );
  logic [25:0]   ram [0:1023];
  logic [24:0]   exp_q[$];
  logic [AW-1:0] exp_f[$];
  logic [AW-1:0] fetch_q[$];
  int            pulse_t[$];
  int            fetch_t[$];
  int            done_t;
  int            n_chk = 0;
  int            n_err = 0;
  int            n_done = 0;
  int            n_pulse = 0;
  int            dly_max = 0;
  bit            dly_rand = 0;
  always #5 clk = ~clk;
  // synchronous-read display-list RAM
  always @(posedge clk) if (bus.mem_rd) bus.mem_data <= ram[bus.mem_addr];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [25:0] wd(input logic [1:0] op, input int x, input int y);
    return {op, 12'(x), 12'(y)};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // reference: one frame is the walk from base to HALT, skipping NOPs, then the park jump
  task automatic model_frame(input logic [AW-1:0] b);
    logic [AW-1:0] a;
    a = b;
    for (int n = 0; n < 1024; n++) begin
      exp_f.push_back(a);
      if (ram[a][25:24] == 2'b10) break;
      if (ram[a][25:24] != 2'b11) exp_q.push_back({ram[a][24], ram[a][23:0]});
      a = a + 10'd1;
    end
    exp_q.push_back({1'b1, 24'h0});
  endtask
  task automatic clear_q();
    exp_q.delete(); exp_f.delete(); fetch_q.delete(); pulse_t.delete(); fetch_t.delete();
  endtask
  task automatic start_pulse(input logic [AW-1:0] b);
    i_base_addr = b;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 5000 && o_busy; i++) tick();
    if (o_busy) chk("idle_timeout", o_busy, 0);
  endtask
  task automatic run_frame(input logic [AW-1:0] b);
    int d0;
    clear_q();
    model_frame(b);
    d0 = n_done;
    start_pulse(b);
    wait_idle();
    chk("leftover_cmds", exp_q.size(), 0);
    chk("frame_count", n_done - d0, 1);
    chk("fetch_cnt", fetch_q.size(), exp_f.size());
    for (int i = 0; i < fetch_q.size() && i < exp_f.size(); i++) chk("fetch_addr", fetch_q[i], exp_f[i]);
  endtask
  task automatic load_t1(input logic [AW-1:0] b);
    ram[b]         = wd(2'b01, 50, 10);
    ram[b + 10'd1] = wd(2'b00, 0, 40);
    ram[b + 10'd2] = wd(2'b00, 50, 50);
    ram[b + 10'd3] = wd(2'b00, 0, 0);
    ram[b + 10'd4] = wd(2'b10, 0, 0);
  endtask
  // monitor + drawer model: checks every pulse against the scoreboard, then drops ready after pulses
  initial begin
    int            hold;
    int            cyc;
    bit            prev_ready;
    bit            first_fetch;
    logic [23:0]   prev_xy;
    logic [AW-1:0] base;
    hold = 0; cyc = 0; prev_ready = 1; first_fetch = 0; prev_xy = '0; base = '0;
    bus.ready = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        if (bus.draw || bus.jump) begin
          n_pulse++;
          pulse_t.push_back(cyc);
          if (bus.draw && bus.jump) chk("draw_and_jump", {bus.draw, bus.jump}, 2'b10);
          chk("ready_at_pulse", bus.ready, 1);
          if (!prev_ready) chk("xy_stable", {bus.x, bus.y}, prev_xy);
          if (exp_q.size() == 0) chk("extra_pulse", exp_q.size(), 1);
          else chk("pulse", {bus.jump, bus.x, bus.y}, exp_q.pop_front());
          hold = dly_rand ? int'($urandom_range(0, dly_max)) : dly_max;
        end else if (hold > 0) hold--;
        if (i_start && !o_busy) begin first_fetch = 1; base = i_base_addr; end
        if (bus.mem_rd) begin
          fetch_q.push_back(bus.mem_addr);
          fetch_t.push_back(cyc);
          if (first_fetch) chk("frame_base", bus.mem_addr, base);
          first_fetch = 0;
        end
        if (o_frame_done) begin n_done++; done_t = cyc; first_fetch = 1; base = i_base_addr; end
        prev_ready = bus.ready;
        prev_xy = {bus.x, bus.y};
      end else hold = 0;
      @(posedge clk);
      #1;
      bus.ready = hold == 0;
    end
  end
  initial begin
    int            d0;
    int            p0;
    logic [AW-1:0] b;
    logic [1:0]    op;
    int            n;
    reset = 1'b0; i_start = 1'b0; i_stop = 1'b0; i_loop_en = 1'b0; i_base_addr = '0;
    for (int i = 0; i < 1024; i++) ram[i] = wd(2'b10, 0, 0);
    #3;
    chk("reset_outputs", {bus.draw, bus.jump, o_busy, o_frame_done, bus.mem_rd, bus.mem_addr, bus.x, bus.y}, 0);
    tick();
    reset = 1'b1;
    tick(); tick();
    // basic list, drawer always ready: order, latency and throughput
    load_t1(10'h000);
    run_frame(10'h000);
    if (pulse_t.size() >= 2 && fetch_t.size() >= 1) begin
      chk("fetch_to_pulse", pulse_t[0] - fetch_t[0], 3);
      chk("cmd_period", pulse_t[1] - pulse_t[0], 4 + HO);
      chk("park_to_done", done_t - pulse_t[pulse_t.size()-1], HO + 1);
    end else chk("t1_pulse_cnt", pulse_t.size(), 5);
    // slow drawer: ready low 20 cycles after each pulse
    dly_max = 20;
    run_frame(10'h000);
    // looping frames at 0x100, stop during the second command of frame 3
    load_t1(10'h100);
    clear_q();
    model_frame(10'h100);
    model_frame(10'h100);
    exp_q.push_back({1'b1, 12'd50, 12'd10});
    exp_q.push_back({1'b0, 12'd0, 12'd40});
    exp_q.push_back({1'b1, 24'h0});
    d0 = n_done;
    i_loop_en = 1'b1;
    start_pulse(10'h100);
    for (int i = 0; i < 3000 && n_done < d0 + 2; i++) tick();
    if (n_done < d0 + 2) chk("loop_wait", n_done - d0, 2);
    p0 = n_pulse;
    for (int i = 0; i < 500 && n_pulse < p0 + 2; i++) tick();
    if (n_pulse < p0 + 2) chk("stop_wait", n_pulse - p0, 2);
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    wait_idle();
    i_loop_en = 1'b0;
    chk("loop_leftover", exp_q.size(), 0);
    chk("loop_frames", n_done - d0, 3);
    dly_max = 0;
    // NOPs and address wrap 0x3FF -> 0x000
    ram[10'h3FC] = wd(2'b11, 1, 1);
    ram[10'h3FD] = wd(2'b00, 100, 200);
    ram[10'h3FE] = wd(2'b11, 7, 7);
    ram[10'h3FF] = wd(2'b00, 300, 400);
    ram[10'h000] = wd(2'b10, 0, 0);
    p0 = n_pulse;
    run_frame(10'h3FC);
    chk("nop_pulses", n_pulse - p0, 3);
    chk("wrap_fetch", fetch_q.size() > 0 ? fetch_q[fetch_q.size()-1] : 10'h3FF, 10'h000);
    // asynchronous reset during HOLD of command 2, then replay
    load_t1(10'h000);
    clear_q();
    model_frame(10'h000);
    p0 = n_pulse;
    start_pulse(10'h000);
    for (int i = 0; i < 200 && n_pulse < p0 + 2; i++) tick();
    if (n_pulse < p0 + 2) chk("hold_wait", n_pulse - p0, 2);
    #2 reset = 1'b0;
    #1;
    chk("async_reset", {bus.draw, bus.jump, o_busy, o_frame_done, bus.mem_rd, bus.mem_addr, bus.x, bus.y}, 0);
    clear_q();
    tick();
    reset = 1'b1;
    tick();
    run_frame(10'h000);
    // start while busy is ignored
    ram[10'h200] = wd(2'b10, 0, 0);
    clear_q();
    model_frame(10'h000);
    d0 = n_done;
    start_pulse(10'h000);
    repeat (6) tick();
    start_pulse(10'h200);
    i_base_addr = 10'h000;
    wait_idle();
    chk("busy_start_left", exp_q.size(), 0);
    chk("busy_start_frames", n_done - d0, 1);
    // start and stop together from idle: park only
    clear_q();
    exp_q.push_back({1'b1, 24'h0});
    d0 = n_done;
    p0 = n_pulse;
    i_base_addr = 10'h000;
    i_start = 1'b1;
    i_stop = 1'b1;
    tick();
    i_start = 1'b0;
    i_stop = 1'b0;
    wait_idle();
    chk("startstop_pulses", n_pulse - p0, 1);
    chk("startstop_frames", n_done - d0, 1);
    chk("startstop_left", exp_q.size(), 0);
    // random lists, random drawer latency
    dly_rand = 1;
    dly_max = 4;
    repeat (6) begin
      b = AW'($urandom_range(0, 1023));
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) begin
        op = 2'($urandom_range(0, 2));
        ram[b + AW'(k)] = wd(op == 2'd2 ? 2'b11 : op, $urandom_range(0, 4095), $urandom_range(0, 4095));
      end
      ram[b + AW'(n)] = wd(2'b10, 0, 0);
      run_frame(b);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
